// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port 256x8 program/data memory of the RISC SPM between
// the processor (CPU port) and the program loader/debug port (DBG port).
//
// Build option: define ARB_FAIR_EN to enable burst limiting. With it, an owner that has held the
// memory for MAX_BURST cycles while the other port was waiting is preempted. Without it, an
// owner keeps the memory until it drops its request. In both builds DBG wins from idle.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i CPU request, write enable, address, write data
//   cpu_gnt_o                     CPU owns the memory this cycle (registered)
//   cpu_stall_o                   CPU is requesting but not granted; freezes the control unit
//   dbg_req_i/we_i/addr_i/wdata_i loader/debug request, same meaning as the CPU port
//   dbg_gnt_o                     DBG owns the memory this cycle (registered)
//   mem_rdata_i                   asynchronous read data from the memory
//   rdata_o                       read data broadcast to both ports
//   mem_addr_o/mem_wdata_o        owner's address/write data, 0 when idle
//   mem_we_o                      write strobe, only for a granted, requesting, writing owner
module mem_port_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_gnt_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o
);

  typedef enum logic [1:0] {StIdle, StOwnCpu, StOwnDbg} state_e;

  state_e state_q, state_d;
  state_e other_st;
  logic   cpu_gnt_q, dbg_gnt_q;
  logic   owner_req, other_req;

`ifdef ARB_FAIR_EN
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BURST - 1);

  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
`endif

  // Next-state decode
  always_comb begin
    state_d   = state_q;
    owner_req = 1'b0;
    other_req = 1'b0;
    other_st  = StIdle;
    unique case (state_q)
      StIdle: begin
        if (dbg_req_i) begin
          state_d = StOwnDbg;
        end else if (cpu_req_i) begin
          state_d = StOwnCpu;
        end
      end
      StOwnCpu: begin
        owner_req = cpu_req_i;
        other_req = dbg_req_i;
        other_st  = StOwnDbg;
      end
      StOwnDbg: begin
        owner_req = dbg_req_i;
        other_req = cpu_req_i;
        other_st  = StOwnCpu;
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      // Release hands over directly to a waiting port, no idle cycle in between.
      if (!owner_req) begin
        state_d = other_req ? other_st : StIdle;
      end
`ifdef ARB_FAIR_EN
      else if (other_req && (burst_cnt_q == LastCnt)) begin
        state_d = other_st;
      end
`endif
    end
  end

`ifdef ARB_FAIR_EN
  // Counts only contended cycles, so an uncontended owner can never be preempted.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_d != state_q) begin
      burst_cnt_d = '0;
    end else if ((state_q != StIdle) && other_req) begin
      burst_cnt_d = burst_cnt_q + CntW'(1);
    end
  end
`endif

  // State and registered grants
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cpu_gnt_q   <= 1'b0;
      dbg_gnt_q   <= 1'b0;
`ifdef ARB_FAIR_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cpu_gnt_q   <= (state_d == StOwnCpu);
      dbg_gnt_q   <= (state_d == StOwnDbg);
`ifdef ARB_FAIR_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  // Memory-side mux follows the owner, not the request, so the address is stable while owned.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    unique case (state_q)
      StOwnCpu: begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_we_o    = cpu_req_i & cpu_we_i & cpu_gnt_q;
      end
      StOwnDbg: begin
        mem_addr_o  = dbg_addr_i;
        mem_wdata_o = dbg_wdata_i;
        mem_we_o    = dbg_req_i & dbg_we_i & dbg_gnt_q;
      end
      default: ;
    endcase
  end

  assign cpu_gnt_o   = cpu_gnt_q;
  assign dbg_gnt_o   = dbg_gnt_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_gnt_q;
  assign rdata_o     = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned MaxBurst = 4;
`ifdef ARB_FAIR_EN
  localparam bit Fair = 1'b1;
`else
  localparam bit Fair = 1'b0;
`endif

  localparam int OwnNone = 0;
  localparam int OwnCpu  = 1;
  localparam int OwnDbg  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic       cpu_gnt, cpu_stall, dbg_gnt, mem_we;
  logic [7:0] mem_rdata, rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;
  int we_seen = 0;

  // Reference model state: who owns the memory and how many contended cycles it has used.
  int m_owner = OwnNone;
  int m_used  = 0;

  logic [7:0] tb_mem  [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  always #5 clk = ~clk;

  // Behavioural memory attached to the arbiter
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_addr];

  mem_port_arbiter #(
    .AW       (8),
    .DW       (8),
    .MAX_BURST(MaxBurst)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o  (cpu_gnt),
    .cpu_stall_o(cpu_stall),
    .dbg_req_i  (dbg_req),
    .dbg_we_i   (dbg_we),
    .dbg_addr_i (dbg_addr),
    .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o  (dbg_gnt),
    .mem_rdata_i(mem_rdata),
    .rdata_o    (rdata),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_we_o   (mem_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against what the model says for the current owner and inputs.
  task automatic check_outputs();
    logic       e_we;
    logic [7:0] e_addr, e_wdata;
    e_we = 1'b0; e_addr = 8'h00; e_wdata = 8'h00;
    if (m_owner == OwnCpu) begin
      e_we = cpu_req & cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
    end else if (m_owner == OwnDbg) begin
      e_we = dbg_req & dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata;
    end
    chk("cpu_gnt", cpu_gnt, m_owner == OwnCpu);
    chk("dbg_gnt", dbg_gnt, m_owner == OwnDbg);
    chk("cpu_stall", cpu_stall, cpu_req && (m_owner != OwnCpu));
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    if (m_owner == OwnCpu && cpu_req && !cpu_we) chk("cpu_rdata", rdata, ref_mem[cpu_addr]);
    if (m_owner == OwnDbg && dbg_req && !dbg_we) chk("dbg_rdata", rdata, ref_mem[dbg_addr]);
    if (mem_we === 1'b1) we_seen++;
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    bit own_req, oth_req;
    int other;
    if (m_owner == OwnCpu && cpu_req && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    if (m_owner == OwnDbg && dbg_req && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
    if (m_owner == OwnNone) begin
      m_owner = dbg_req ? OwnDbg : (cpu_req ? OwnCpu : OwnNone);
      m_used  = 0;
    end else begin
      own_req = (m_owner == OwnCpu) ? cpu_req : dbg_req;
      oth_req = (m_owner == OwnCpu) ? dbg_req : cpu_req;
      other   = (m_owner == OwnCpu) ? OwnDbg : OwnCpu;
      if (!own_req) begin
        m_owner = oth_req ? other : OwnNone;
        m_used  = 0;
      end else if (oth_req) begin
        m_used++;
        if (Fair && m_used >= int'(MaxBurst)) begin
          m_owner = other;
          m_used  = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic c, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic d, input logic dw, input logic [7:0] da, input logic [7:0] dd);
    cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = d; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  // One clock cycle: drive, check mid-cycle, update model, return 1 time unit after the edge.
  task automatic cycle(input logic c, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic d, input logic dw, input logic [7:0] da, input logic [7:0] dd);
    drive(c, cw, ca, cd, d, dw, da, dd);
    #2;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int we_before;

    // Reset with the CPU already requesting
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_dbg_gnt", dbg_gnt, 1'b0);
    chk("rst_stall", cpu_stall, 1'b1);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_edge_cpu_gnt", cpu_gnt, 1'b0);
    #2;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("grant_after_rst", cpu_gnt, 1'b1);
    chk("stall_after_rst", cpu_stall, 1'b0);

    // DBG writes 0xA5 to 0x10, then the CPU reads it back
    we_before = we_seen;
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
    chk("handover_dbg", dbg_gnt, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
    cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("dbg_write_mem", tb_mem[8'h10], 8'hA5);
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("cpu_read_a5", rdata, 8'hA5);
    cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("one_we_pulse", we_seen - we_before, 1);

    // Simultaneous requests from idle
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
      chk("contend_dbg_gnt", dbg_gnt, Fair ? (((i / MaxBurst) % 2) == 0) : 1'b1);
      chk("contend_cpu_gnt", cpu_gnt, Fair ? (((i / MaxBurst) % 2) == 1) : 1'b0);
    end
    cycle(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h02, 8'h00);
    chk("cpu_after_dbg_drop", cpu_gnt, 1'b1);

    // Uncontended CPU ownership, then DBG arrives
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 21; i++) cycle(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("no_preempt_idle_dbg", cpu_gnt, 1'b1);
    for (int j = 0; j < 6; j++) begin
      cycle(1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'h04, 8'h00);
      chk("preempt_cpu_gnt", cpu_gnt, Fair ? (j + 1 < int'(MaxBurst)) : 1'b1);
    end

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
            8'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15)), 8'($urandom));
    end

    // Reset in the middle of a DBG write
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h5A);
    #1;
    chk("pre_rst_mem_we", mem_we, 1'b1);
    chk("pre_rst_addr", mem_addr, 8'h20);
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_we", mem_we, 1'b0);
    chk("mid_rst_dbg_gnt", dbg_gnt, 1'b0);
    chk("mid_rst_addr", mem_addr, 8'h00);
    chk("mid_rst_wdata", mem_wdata, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_no_commit", tb_mem[8'h20], 8'h00);
    chk("rst_no_commit_ref", tb_mem[8'h20], ref_mem[8'h20]);
    rst = 1'b1;
    m_owner = OwnNone;
    m_used  = 0;
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single-port 256x8 program/data memory of the RISC SPM. It shares the memory between the processor's address/write path (CPU port) and the program loader/debug port (DBG port). It uses a registered request/grant handshake and bounded bursts under contention. It also drives a stall to the processor so the control unit holds state while the CPU port is not granted.

## Interface
- `AW`, 8: address width.
- `DW`, 8: data width.
- `MAX_BURST`, 4: maximum consecutive granted cycles for one owner while the other port is requesting; legal range ≥1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset rst, asynchronous, active-low.
- `cpu_req`  in  1  CPU requests memory; held for the whole transaction.
- `cpu_we`  in  1  CPU access is a write.
- `cpu_addr`  in  AW  CPU address (from Add_R).
- `cpu_wdata`  in  DW  CPU write data (Bus_1).
- `cpu_gnt`  out  1  CPU owns memory this cycle (registered).
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`; freezes the control unit.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/1/AW/DW  loader/debug port, same meaning as CPU port.
- `dbg_gnt`  out  1  DBG owns memory this cycle (registered).
- `mem_rdata`  in  DW  asynchronous read data from memory.
- `rdata`  out  DW  `mem_rdata` broadcast to both ports; valid only for the granted port.
- `mem_addr`  out  AW  owner's address; 0 when idle.
- `mem_wdata`  out  DW  owner's write data; 0 when idle.
- `mem_we`  out  1  `owner_req & owner_we & owner_gnt`; never asserted when idle.

## Operation
- FSM states: IDLE, OWN_CPU, OWN_DBG. `cpu_gnt` is 1 only in OWN_CPU and `dbg_gnt` only in OWN_DBG; the two are never both 1.
- IDLE:
  - dbg_req → OWN_DBG.
  - else cpu_req → OWN_CPU.
  - else stay IDLE.
  - Simultaneous requests: DBG wins.
- OWN_x:
  - owner_req=0 → other_req ? OWN_other : IDLE. Hand-over is direct, with no idle cycle.
  - owner_req=1, other_req=1, burst_cnt==MAX_BURST-1 → OWN_other (preemption).
  - otherwise stay.
- `burst_cnt` (width `$clog2(MAX_BURST+1)`):
  - Cleared on every state change.
  - Increments each cycle in OWN_x while other_req=1.
  - Holds while other_req=0, so an uncontended owner is never preempted.
- A preempted requester sees gnt drop with its req still high. It must keep req high and wait for gnt to return. It must not consider the access in the gnt=0 cycle as performed.
- An access is performed exactly in each cycle where req&gnt=1. Writes commit on that clock edge. Read data is valid combinationally in that same cycle.
- Mux: mem_addr/mem_wdata select the port by state, independent of req.
- MAX_BURST=1: strict alternation under continuous contention.

## Timing
- Reset (asynchronous): state=IDLE, burst_cnt=0, cpu_gnt=0, dbg_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0. cpu_stall equals cpu_req during reset.
- Grant latency: req sampled high at edge N (from IDLE, or at release) → gnt=1 after edge N, i.e. one cycle.
- Release latency: req low at edge N → gnt=0 after edge N; the other port's gnt rises after the same edge N.
- Preemption: owner loses gnt after the edge on which its MAX_BURST-th contended cycle completed.
- Reset mid-transaction: grant is lost immediately and any write in that cycle is not committed (mem_we=0 asynchronously).
- Requests asserted by a port during its own gnt=0 cycle are not lost; they are evaluated at the next edge.

## Configuration
- `ARB_FAIR_EN` defined: burst limiting and preemption active as described above.
- Not defined:
  - burst_cnt is removed.
  - The owner keeps the grant until it drops req, so there is no preemption.
  - IDLE priority is unchanged (DBG first).

## Test plan
- Reset with cpu_req=1: all grants 0 and cpu_stall=1. After release, cpu_gnt=1 one cycle later and cpu_stall=0.
- DBG writes 0xA5 to address 0x10, then CPU reads address 0x10: mem_we=1 for exactly one cycle with mem_addr=0x10, and CPU rdata=0xA5.
- Both request from IDLE in the same cycle: dbg_gnt=1 and cpu_gnt=0. With `ARB_FAIR_EN` and MAX_BURST=4, DBG gets 4 cycles, then CPU gets 4 cycles, alternating.
- Same stimulus without `ARB_FAIR_EN`: DBG holds the grant until it drops dbg_req. cpu_gnt rises the cycle after dbg_req falls.
- CPU owns, DBG idle for 20 cycles: no preemption and burst_cnt stays 0. Raising dbg_req then causes preemption after 4 cycles.
- Assert rst during a DBG write cycle: mem_we drops immediately, the target address keeps its old value, and state returns to IDLE.
